// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the off-chip IO bus: controller states, bus owner and pad mode encodings.
package io_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_SETUP,
        TX_ACTIVE,
        TX_RELEASE,
        RX_ACTIVE
    } bus_state_t;

    typedef enum logic {
        OWNER_TX,
        OWNER_RX
    } owner_t;

    // mode_sel encoding shared with the IO bus block
    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

endpackage

// File: rtl/io_bus_dir_ctrl_turn_timer.sv
// Guard-gap timer: loads TURN_CYC-1 on entry to SETUP/RELEASE and flags done when it reaches zero.
module turn_timer #(
    parameter int TURN_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(TURN_CYC - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/io_bus_dir_ctrl.sv
// Shared IO bus direction controller: TX/RX arbitration, guarded turnaround and burst-length preemption.
module io_bus_dir_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_req,
    input  logic tx_last,
    input  logic rx_req,
    input  logic rx_last,
    output logic tx_gnt,
    output logic rx_gnt,
    output logic mode_sel,
    output logic mod_en,
    output logic dem_en,
    output logic busy,
    output logic preempt
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

    bus_state_t       state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             tx_gnt_q, tx_gnt_d;
    logic             rx_gnt_q, rx_gnt_d;
    logic             mode_sel_q, mode_sel_d;
    logic             mod_en_q, mod_en_d;
    logic             dem_en_q, dem_en_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;
    logic             timer_load;
    logic             timer_done;
    logic             at_lim;

    turn_timer #(
        .TURN_CYC(TURN_CYC)
    ) u_turn_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .done (timer_done)
    );

    assign at_lim = (burst_cnt_q == CNT_LIM);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        preempt_d    = 1'b0;
        timer_load   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the side that did not own the bus last wins
                if (tx_req && (!rx_req || last_owner_q == OWNER_RX)) begin
                    state_d      = TX_SETUP;
                    last_owner_d = OWNER_TX;
                    timer_load   = 1'b1;
                end else if (rx_req) begin
                    state_d      = RX_ACTIVE;
                    last_owner_d = OWNER_RX;
                    burst_cnt_d  = '0;
                end
            end
            TX_SETUP: begin
                if (timer_done) begin
                    state_d     = TX_ACTIVE;
                    burst_cnt_d = '0;
                end
            end
            TX_ACTIVE: begin
                if (tx_last || !tx_req || (at_lim && rx_req)) begin
                    state_d    = TX_RELEASE;
                    timer_load = 1'b1;
                    // Only a pure limit cut counts as preemption, not a natural end
                    preempt_d  = tx_req && !tx_last;
                end else if (!at_lim) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            TX_RELEASE: begin
                if (timer_done) begin
                    state_d = IDLE;
                end
            end
            RX_ACTIVE: begin
                if (rx_last || !rx_req || (at_lim && tx_req)) begin
                    state_d   = IDLE;
                    preempt_d = rx_req && !rx_last;
                end else if (!at_lim) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q
        tx_gnt_d   = (state_d == TX_ACTIVE);
        rx_gnt_d   = (state_d == RX_ACTIVE);
        mode_sel_d = (state_d == TX_ACTIVE) ? MODE_TX : MODE_RX;
        mod_en_d   = (state_d == TX_SETUP) || (state_d == TX_ACTIVE);
        dem_en_d   = (state_d == RX_ACTIVE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_RX;
            burst_cnt_q  <= '0;
            tx_gnt_q     <= 1'b0;
            rx_gnt_q     <= 1'b0;
            mode_sel_q   <= MODE_RX;
            mod_en_q     <= 1'b0;
            dem_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_gnt_q     <= tx_gnt_d;
            rx_gnt_q     <= rx_gnt_d;
            mode_sel_q   <= mode_sel_d;
            mod_en_q     <= mod_en_d;
            dem_en_q     <= dem_en_d;
            busy_q       <= busy_d;
            preempt_q    <= preempt_d;
        end
    end

    assign tx_gnt   = tx_gnt_q;
    assign rx_gnt   = rx_gnt_q;
    assign mode_sel = mode_sel_q;
    assign mod_en   = mod_en_q;
    assign dem_en   = dem_en_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;

endmodule
